// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage constants, next-PC select encoding and address helper
package fetch_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_HOLD   = 2'd1,
    SEL_BRANCH = 2'd2,
    SEL_JUMP   = 2'd3
  } pc_sel_e;
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/pc_unit.sv
// pc_unit: PC register with prioritised next-PC mux (branch > jump > stall > sequential)
module pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        redirect
);
  pc_sel_e     sel;
  logic [31:0] pc_next;
  always_comb begin
    sel = branch_taken ? SEL_BRANCH : jump ? SEL_JUMP : stall ? SEL_HOLD : SEL_SEQ;
    pc_next = sel == SEL_BRANCH ? align_word(branch_target) :
              sel == SEL_JUMP   ? align_word(jump_target)   :
              sel == SEL_HOLD   ? pc : pc_plus4;
  end
  assign pc_plus4 = pc + 32'd4;
  assign redirect = branch_taken | jump;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_next;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencing plus IF/ID pipeline register with stall, flush and redirect.
// Optional FETCH_PERF_COUNTERS_EN adds FetchCount/StallCount outputs.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] ImemAddress,
  input  logic [31:0] ImemInstruction,
  output logic [31:0] IfId_Instruction,
  output logic [31:0] IfId_PCPlus4,
`ifdef FETCH_PERF_COUNTERS_EN
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount,
`endif
  output logic        IfId_Valid
);
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        squash;
  logic        capture;
  pc_unit #(.RESET_PC(RESET_PC)) u_pc (
    .clk          (Clk),
    .rst_n        (Rst),
    .stall        (Stall),
    .branch_taken (BranchTaken),
    .branch_target(BranchTarget),
    .jump         (Jump),
    .jump_target  (JumpTarget),
    .pc           (ImemAddress),
    .pc_plus4     (pc_plus4),
    .redirect     (redirect)
  );
  // redirect and flush both bubble IF/ID; stall only holds when neither is present
  assign squash  = redirect | Flush;
  assign capture = !squash && !Stall;
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      IfId_Instruction <= NOP_WORD;
      IfId_PCPlus4     <= '0;
      IfId_Valid       <= 1'b0;
    end else if (squash) begin
      IfId_Instruction <= NOP_WORD;
      IfId_PCPlus4     <= '0;
      IfId_Valid       <= 1'b0;
    end else if (capture) begin
      IfId_Instruction <= ImemInstruction;
      IfId_PCPlus4     <= pc_plus4;
      IfId_Valid       <= 1'b1;
    end
`ifdef FETCH_PERF_COUNTERS_EN
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      FetchCount <= '0;
      StallCount <= '0;
    end else begin
      if (capture)         FetchCount <= FetchCount + 32'd1;
      if (!squash && Stall) StallCount <= StallCount + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, br = 1'b0, jmp = 1'b0;
  logic [31:0] br_tgt = '0, jmp_tgt = '0;
  logic [31:0] addr, instr, if_instr, if_pc4;
  logic        if_valid;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign instr = mem(addr);

  fetch_stage dut (
    .Clk             (clk),
    .Rst             (rst),
    .Stall           (stall),
    .Flush           (flush),
    .BranchTaken     (br),
    .BranchTarget    (br_tgt),
    .Jump            (jmp),
    .JumpTarget      (jmp_tgt),
    .ImemAddress     (addr),
    .ImemInstruction (instr),
    .IfId_Instruction(if_instr),
    .IfId_PCPlus4    (if_pc4),
`ifdef FETCH_PERF_COUNTERS_EN
    .FetchCount      (fetch_cnt),
    .StallCount      (stall_cnt),
`endif
    .IfId_Valid      (if_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] a, input logic [31:0] i,
                            input logic [31:0] p, input logic v);
    check({tag, "_addr"}, addr, a);
    check({tag, "_instr"}, if_instr, i);
    check({tag, "_pc4"}, if_pc4, p);
    check({tag, "_valid"}, {31'd0, if_valid}, {31'd0, v});
  endtask

  initial begin
    repeat (3) step();
    check_ifid("rst_hold", 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    check_ifid("rst_rel", 32'h0, 32'h0, 32'h0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check_ifid($sformatf("seq%0d", i), 32'(4 * i), mem(32'(4 * (i - 1))), 32'(4 * i), 1'b1);
    end
    repeat (4) step();
    check("pc_20", addr, 32'h20);
    #2 rst = 1'b0;
    #1;
    check_ifid("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_COUNTERS_EN
    check("async_fetch_cnt", fetch_cnt, 32'h0);
    check("async_stall_cnt", stall_cnt, 32'h0);
`endif
    #1 rst = 1'b1;
    step();
    check_ifid("post_rst", 32'h4, mem(32'h0), 32'h4, 1'b1);
    jmp = 1'b1; jmp_tgt = 32'h10;
    step();
    check_ifid("jump", 32'h10, 32'h0, 32'h0, 1'b0);
    jmp = 1'b0;
    step();
    check_ifid("jump_fetch", 32'h14, mem(32'h10), 32'h14, 1'b1);
    repeat (5) step();
    check_ifid("pre_stall", 32'h28, mem(32'h24), 32'h28, 1'b1);
    stall = 1'b1;
    step();
    check_ifid("stall1", 32'h28, mem(32'h24), 32'h28, 1'b1);
    step();
    check_ifid("stall2", 32'h28, mem(32'h24), 32'h28, 1'b1);
`ifdef FETCH_PERF_COUNTERS_EN
    check("fetch_cnt", fetch_cnt, 32'd7);
    check("stall_cnt", stall_cnt, 32'd2);
`endif
    br = 1'b1; br_tgt = 32'h3A;
    step();
    check_ifid("stall_branch", 32'h38, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_COUNTERS_EN
    check("stall_cnt_redir", stall_cnt, 32'd2);
`endif
    stall = 1'b0;
    br_tgt = 32'h38; jmp = 1'b1; jmp_tgt = 32'hDC;
    step();
    check_ifid("br_over_jmp", 32'h38, 32'h0, 32'h0, 1'b0);
    br = 1'b0; jmp = 1'b0;
    step();
    check_ifid("after_br", 32'h3C, mem(32'h38), 32'h3C, 1'b1);
    flush = 1'b1;
    step();
    check_ifid("flush", 32'h40, 32'h0, 32'h0, 1'b0);
    flush = 1'b0;
    jmp = 1'b1; jmp_tgt = 32'hFFFF_FFFF;
    step();
    check("jump_mask", addr, 32'hFFFF_FFFC);
    jmp = 1'b0;
    step();
    check_ifid("wrap", 32'h0, mem(32'hFFFF_FFFC), 32'h0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, the PC value loaded on reset.
REQ-002 SHALL have parameter NOP_WORD, default 32'h00000000, the instruction word injected into IF/ID on flush or bubble.
REQ-003 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port Stall, input, 1, hazard stall from decode; holds the PC and IF/ID.
REQ-006 SHALL have port Flush, input, 1, squash of the IF/ID contents.
REQ-007 SHALL have port BranchTaken, input, 1, branch redirect request.
REQ-008 SHALL have port BranchTarget, input, 32, branch destination byte address.
REQ-009 SHALL have port Jump, input, 1, jump/jr/jal redirect request.
REQ-010 SHALL have port JumpTarget, input, 32, jump destination byte address.
REQ-011 SHALL have port ImemAddress, output, 32, current PC driven to the instruction memory Address input.
REQ-012 SHALL have port ImemInstruction, input, 32, combinational instruction word returned for ImemAddress.
REQ-013 SHALL have port IfId_Instruction, output, 32, registered instruction for decode.
REQ-014 SHALL have port IfId_PCPlus4, output, 32, registered PC+4 of that instruction.
REQ-015 SHALL have port IfId_Valid, output, 1, high when the IF/ID contents are a real fetched instruction.

Function
REQ-016 ImemAddress SHALL equal the PC register with no added latency; the instruction is sampled into IF/ID at the same edge that advances the PC (1-cycle fetch latency).
REQ-017 Next-PC priority SHALL be: BranchTaken (BranchTarget) > Jump (JumpTarget) > Stall (hold PC) > sequential (PC+4).
REQ-018 A redirect SHALL override Stall, and SHALL load IF/ID with NOP_WORD, IfId_Valid=0, and IfId_PCPlus4=0 at the same edge.
REQ-019 Flush without a redirect SHALL load IF/ID with NOP_WORD and IfId_Valid=0 while the PC follows REQ-017.
REQ-020 Stall without a redirect or Flush SHALL hold both the PC and all IF/ID outputs unchanged.
REQ-021 Otherwise IF/ID SHALL capture ImemInstruction, PC+4, and IfId_Valid=1.
REQ-022 Redirect targets SHALL have bits [1:0] forced to 2'b00 before loading the PC.
REQ-023 PC+4 SHALL be computed modulo 2^32; 32'hFFFFFFFC wraps to 32'h00000000 with no flag.
REQ-024 Simultaneous BranchTaken and Jump SHALL take BranchTarget only.

Reset
REQ-025 While Rst=0, the PC SHALL equal RESET_PC, IfId_Instruction=NOP_WORD, IfId_PCPlus4=0, and IfId_Valid=0, immediately and independent of Clk.
REQ-026 Reset asserted mid-operation SHALL discard any pending redirect or stall.
REQ-027 The first edge after Rst rises SHALL fetch from RESET_PC.

Configuration
REQ-028 With macro FETCH_PERF_COUNTERS_EN defined, the block SHALL add outputs FetchCount[31:0] and StallCount[31:0].
- FetchCount SHALL increment on each edge that captures IfId_Valid=1.
- StallCount SHALL increment on each edge where REQ-020 applies.
- Both SHALL reset to 0 and wrap at 2^32.
REQ-029 Without FETCH_PERF_COUNTERS_EN, these ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-030 Shared package fetch_pkg SHALL hold the RESET_PC and NOP_WORD default constants and the 2-bit next-PC select encoding (SEQ, HOLD, BRANCH, JUMP).
REQ-031 The PC register with next-PC mux SHALL be a sub-module named pc_unit; the IF/ID register and counters SHALL reside in fetch_stage.

Verification
REQ-032 Reset test: hold Rst=0 for 3 cycles, then release -> ImemAddress=0x0, IfId_Valid=0, and after the first edge IfId_PCPlus4=0x4, IfId_Valid=1.
REQ-033 Sequential fetch: 4 free-running cycles -> ImemAddress steps 0x0, 0x4, 0x8, 0xC, and IfId_Instruction equals the memory word at each prior address.
REQ-034 Jump: Jump=1, JumpTarget=0x10 at PC=0x4 -> next ImemAddress=0x10, IF/ID=NOP_WORD, IfId_Valid=0, then the fetch at 0x10 is valid.
REQ-035 Stall plus redirect: Stall=1 for 2 cycles holds PC=0x28 and IF/ID; Stall=1, BranchTaken=1, BranchTarget=0x3A in the same cycle -> PC=0x38 and IfId_Valid=0.
REQ-036 Priority and wrap: BranchTaken=1 (0x38) with Jump=1 (0xDC) -> PC=0x38; separately, PC=0xFFFFFFFC sequential -> PC=0x0.
REQ-037 Asynchronous reset mid-stream: Rst pulsed low between edges at PC=0x20 -> outputs reset without a clock edge; with FETCH_PERF_COUNTERS_EN, both counters read 0.
